// File: rtl/fpu_add_scheduler.sv
// fpu_add_scheduler: round-robin time-sharing of one fp32 adder between NREQ requesters.
// fpu_add_core is the shared combinational single-precision adder it drives.
module fpu_add_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    output logic [31:0] result,
    output logic        overflow,
    output logic        error
);
    logic        a_nan, b_nan, a_inf, b_inf, invalid, swap, sub, sgn, inc, zero;
    logic [31:0] big, sml, packed_r;
    logic [7:0]  e_big, e_sml, d, d_c;
    logic [23:0] sig_big, sig_sml;
    logic [53:0] shifted;
    logic [26:0] aligned, m_n;
    logic [27:0] sum;
    logic [8:0]  e_n;
    logic [4:0]  lz, sh;

    always_comb begin
        a_nan    = (&a[30:23]) && (|a[22:0]);
        b_nan    = (&b[30:23]) && (|b[22:0]);
        a_inf    = (&a[30:23]) && !(|a[22:0]);
        b_inf    = (&b[30:23]) && !(|b[22:0]);
        sub      = a[31] ^ b[31];
        invalid  = a_nan || b_nan || (a_inf && b_inf && sub);
        swap     = b[30:0] > a[30:0];
        big      = swap ? b : a;
        sml      = swap ? a : b;
        sgn      = big[31];
        e_big    = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        e_sml    = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        sig_big  = {|big[30:23], big[22:0]};
        sig_sml  = {|sml[30:23], sml[22:0]};
        d        = e_big - e_sml;
        d_c      = (d > 8'd30) ? 8'd30 : d;
        // Smaller operand aligned to 24 bits + guard + round + sticky
        shifted  = {sig_sml, 30'd0} >> d_c;
        aligned  = {shifted[53:28], |shifted[27:0]};
        sum      = sub ? {1'b0, sig_big, 3'd0} - {1'b0, aligned}
                       : {1'b0, sig_big, 3'd0} + {1'b0, aligned};
        zero     = (sum == 28'd0);
        lz       = 5'd27;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
        // Left normalisation stops at the minimum exponent, leaving a subnormal
        sh       = ({3'd0, lz} < (e_big - 8'd1)) ? lz : 5'(e_big - 8'd1);
        m_n      = sum[27] ? {sum[27:2], |sum[1:0]} : (sum[26:0] << sh);
        e_n      = sum[27] ? ({1'b0, e_big} + 9'd1)
                 : (m_n[26] ? ({1'b0, e_big} - {4'd0, sh}) : 9'd0);
        inc      = (rm == 2'b01) ? (m_n[2] && ((|m_n[1:0]) || m_n[3]))
                 : (rm == 2'b10) ? (!sgn && (|m_n[2:0]))
                 : (rm == 2'b11) ? (sgn && (|m_n[2:0])) : 1'b0;
        packed_r = {e_n, m_n[25:3]} + {31'd0, inc};
        overflow = !(invalid || a_inf || b_inf) && (packed_r[31:23] >= 9'd255);
        error    = invalid || overflow;
        result   = invalid ? 32'h7FC0_0000
                 : a_inf   ? a
                 : b_inf   ? b
                 : zero    ? {(sub ? (rm == 2'b11) : a[31]), 31'd0}
                 : {sgn, packed_r[30:0]};
    end
endmodule

module fpu_add_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [2*NREQ-1:0]    req_rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic                 out_overflow,
    output logic                 out_error,
    output logic [IDW-1:0]       out_id,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q, last_d, id_q, id_d, oid_q, oid_d, gnt_id, cand;
    logic [31:0]    a_q, a_d, b_q, b_d, res_q, res_d, add_res;
    logic [1:0]     rm_q, rm_d;
    logic           ovf_q, ovf_d, err_q, err_d, add_ovf, add_err, gnt_any, accept, cap;

    fpu_add_core u_adder (
        .a        (a_q),
        .b        (b_q),
        .rm       (rm_q),
        .result   (add_res),
        .overflow (add_ovf),
        .error    (add_err)
    );

    // Descending scan so the nearest requester after last_q wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(last_q) + k) % NREQ);
            if (req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rm_q    <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            oid_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rm_q    <= rm_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            oid_q   <= oid_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE && gnt_any)   ? EXEC
                : (state_q == EXEC)              ? DONE
                : (state_q == DONE && out_ready) ? IDLE : state_q;
    end

    always_comb begin
        accept = (state_q == IDLE) && gnt_any;
        cap    = (state_q == EXEC);
        last_d = accept ? gnt_id : last_q;
        id_d   = accept ? gnt_id : id_q;
        a_d    = accept ? req_a[32*gnt_id +: 32] : a_q;
        b_d    = accept ? req_b[32*gnt_id +: 32] : b_q;
        rm_d   = accept ? req_rm[2*gnt_id +: 2] : rm_q;
        // The adder's sum is not meaningful on overflow; substitute a signed infinity
        res_d  = cap ? (add_ovf ? {a_q[31], 8'hFF, 23'd0} : add_res) : res_q;
        ovf_d  = cap ? add_ovf : ovf_q;
        err_d  = cap ? add_err : err_q;
        oid_d  = cap ? id_q : oid_q;
    end

    always_comb begin
        req_ready    = (accept && !rst) ? (NREQ'(1) << gnt_id) : '0;
        busy         = (state_q != IDLE);
        out_valid    = (state_q == DONE);
        out_result   = res_q;
        out_overflow = ovf_q;
        out_error    = err_q;
        out_id       = oid_q;
    end
endmodule

// File: tb/tb_fpu_add_scheduler.sv
// tb_fpu_add_scheduler: directed and randomized checks against an exact-arithmetic reference.
module tb_fpu_add_scheduler;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [32*NREQ-1:0]  req_a, req_b;
    logic [2*NREQ-1:0]   req_rm;
    logic                out_valid, out_ready, out_overflow, out_error, busy;
    logic [31:0]         out_result;
    logic [IDW-1:0]      out_id;

    int n_checks = 0;
    int n_errors = 0;
    int m_phase  = 0;
    int m_last   = NREQ - 1;
    int m_id     = 0;
    int cyc      = 0;
    logic [33:0] m_exp = '0;
    int grants[$];
    int grant_cyc[$];

    always #5 clk = ~clk;

    fpu_add_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_rm       (req_rm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_error    (out_error),
        .out_id       (out_id),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Operand value as an exact signed integer in units of 2^-149
    function automatic logic signed [290:0] to_fixed(input logic [31:0] x);
        logic [290:0] m;
        m = (x[30:23] == 8'd0) ? 291'(x[22:0]) : (291'({1'b1, x[22:0]}) << (x[30:23] - 8'd1));
        return x[31] ? -$signed(m) : $signed(m);
    endfunction

    // Returns {overflow, error, expected out_result}
    function automatic logic [33:0] fp_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        logic a_nan, b_nan, a_inf, b_inf, neg, inc;
        logic signed [290:0] s;
        logic [290:0] mag, keep, rem, half;
        int p, sh, e;
        a_nan = a[30:23] == 8'hFF && a[22:0] != 0;
        b_nan = b[30:23] == 8'hFF && b[22:0] != 0;
        a_inf = a[30:23] == 8'hFF && a[22:0] == 0;
        b_inf = b[30:23] == 8'hFF && b[22:0] == 0;
        if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) return {2'b01, 32'h7FC00000};
        if (a_inf) return {2'b00, a};
        if (b_inf) return {2'b00, b};
        s = to_fixed(a) + to_fixed(b);
        if (s == 0)
            return {2'b00, ((a[31] && b[31]) || (a[31] != b[31] && rm == 2'b11)) ? 32'h80000000 : 32'h0};
        neg = s < 0;
        mag = neg ? 291'(-s) : 291'(s);
        p = 0;
        for (int i = 0; i < 291; i++) if (mag[i]) p = i;
        sh   = (p > 23) ? p - 23 : 0;
        keep = mag >> sh;
        rem  = mag - (keep << sh);
        half = (sh > 0) ? (291'(1) << (sh - 1)) : '0;
        case (rm)
            2'b00:   inc = 1'b0;
            2'b01:   inc = (sh > 0) && (rem > half || (rem == half && keep[0]));
            2'b10:   inc = !neg && rem != 0;
            default: inc = neg && rem != 0;
        endcase
        keep = keep + 291'(inc);
        if (keep[24]) begin
            keep = keep >> 1;
            sh++;
        end
        e = keep[23] ? sh + 1 : 0;
        if (e >= 255) return {2'b11, a[31], 8'hFF, 23'd0};
        return {2'b00, neg, 8'(e), keep[22:0]};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [31:0] rand_fp();
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
            2:       return {1'($urandom), 8'd0, 23'($urandom)};
            3:       return {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
            4:       return {1'($urandom), 8'($urandom_range(1, 3)), 23'($urandom)};
            default: return {1'($urandom), 8'hFF, ($urandom_range(0, 1) != 0) ? 23'd0 : 23'($urandom)};
        endcase
    endfunction

    task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_rm[2*i +: 2]  = rm;
    endtask

    // One clock: apply inputs, compare against the reference, then advance it
    task automatic cycle(input logic [NREQ-1:0] v, input logic ordy);
        int g;
        logic [NREQ-1:0] exp_rdy;
        req_valid = v;
        out_ready = ordy;
        #1;
        g = rr_pick(v, m_last);
        exp_rdy = (m_phase == 0 && !rst && g >= 0) ? (NREQ'(1) << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("out_valid", 32'(out_valid), 32'(m_phase == 2));
        if (m_phase == 2) begin
            check("out_result", out_result, m_exp[31:0]);
            check("out_flags", {30'd0, out_overflow, out_error}, {30'd0, m_exp[33:32]});
            check("out_id", 32'(out_id), 32'(m_id));
        end
        if (rst) begin
            m_phase = 0;
            m_last  = NREQ - 1;
        end else if (m_phase == 0 && g >= 0) begin
            m_exp   = fp_ref(req_a[32*g +: 32], req_b[32*g +: 32], req_rm[2*g +: 2]);
            m_id    = g;
            m_last  = g;
            m_phase = 1;
            grants.push_back(g);
            grant_cyc.push_back(cyc);
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && ordy) begin
            m_phase = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cycle('0, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        int exp_seq[$];
        rst = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        req_rm = '0;
        @(posedge clk);
        #1;
        cycle('1, 1'b1);
        rst = 1'b0;
        check("rst_result", out_result, 32'h0);
        check("rst_id", 32'(out_id), 32'h0);
        check("rst_flags", {30'd0, out_overflow, out_error}, 32'h0);

        set_lane(0, 32'h3F800000, 32'h40000000, 2'b00);
        cycle(4'b0001, 1'b1);
        cycle(4'b0000, 1'b1);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_result", out_result, 32'h40400000);
        check("t1_id", 32'(out_id), 32'h0);
        check("t1_ovf", 32'(out_overflow), 32'h0);
        cycle(4'b0000, 1'b1);

        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_lane(i, 32'h3F800000, 32'h3F800000, 2'b01);
        grants.delete();
        grant_cyc.delete();
        for (int r = 0; r < 5; r++) begin
            cycle('1, 1'b1);
            cycle('1, 1'b1);
            check("t2_result", out_result, 32'h40000000);
            check("t2_id", 32'(out_id), 32'(r % NREQ));
            cycle('1, 1'b1);
        end
        exp_seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            check("t2_order", 32'((i < grants.size()) ? grants[i] : -1), 32'(exp_seq[i]));
            if (i > 0 && i < grant_cyc.size())
                check("t2_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);
        end

        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_lane(i, 32'h40400000, 32'hBF800000, 2'b01);
        repeat (3) cycle(4'b0010, 1'b1);
        grants.delete();
        repeat (12) cycle(4'b1010, 1'b1);
        exp_seq = '{3, 1, 3, 1};
        for (int i = 0; i < 4; i++)
            check("t3_order", 32'((i < grants.size()) ? grants[i] : -1), 32'(exp_seq[i]));

        pulse_reset();
        set_lane(2, 32'h7F000000, 32'h7F000000, 2'b01);
        cycle(4'b0100, 1'b1);
        cycle(4'b0000, 1'b1);
        check("t4_ovf", 32'(out_overflow), 32'h1);
        check("t4_err", 32'(out_error), 32'h1);
        check("t4_result", out_result, 32'h7F800000);
        check("t4_id", 32'(out_id), 32'h2);
        cycle(4'b0000, 1'b1);

        for (int i = 0; i < NREQ; i++) set_lane(i, rand_fp(), rand_fp(), 2'($urandom));
        cycle('1, 1'b0);
        cycle('1, 1'b0);
        held = out_result;
        repeat (10) begin
            for (int i = 0; i < NREQ; i++) set_lane(i, rand_fp(), rand_fp(), 2'($urandom));
            cycle('1, 1'b0);
            check("t5_hold", out_result, held);
        end
        cycle('1, 1'b1);
        check("t5_idle", 32'(busy), 32'h0);
        check("t5_grant", 32'(|req_ready), 32'h1);
        cycle('1, 1'b1);

        rst = 1'b1;
        cycle('1, 1'b1);
        rst = 1'b0;
        check("t6_valid", 32'(out_valid), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        grants.delete();
        cycle(4'b0011, 1'b1);
        check("t6_grant", 32'((grants.size() > 0) ? grants[0] : -1), 32'h0);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                logic [31:0] a;
                a = rand_fp();
                set_lane(i, a, ($urandom_range(0, 3) == 0) ? (a ^ 32'h80000000 ^ 32'($urandom_range(0, 7))) : rand_fp(),
                         2'($urandom));
            end
            rst = ($urandom_range(0, 99) == 0);
            cycle(NREQ'($urandom), $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fpu_add_scheduler.md
# fpu_add_scheduler

- Time-shares one single-precision `Adder` instance between `NREQ` independent requesters.
- Each requester presents an operand pair and a rounding mode through a valid/ready handshake. The block selects one requester by round-robin, registers its operands, and drives the shared combinational adder for one cycle.
- It captures the result, overflow and error into an output register and holds them until the consumer accepts them.
- It sits between the FPU issue logic and the single shared adder datapath.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of the requester index, equal to clog2(`NREQ`).

Ports:
- `clk`, input, 1: sole clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, `NREQ`: bit i set means requester i presents an operation.
- `req_ready`, output, `NREQ`: one-hot grant. Bit i set means requester i's operation is accepted this cycle.
- `req_a`, input, 32*`NREQ`: operand A for requester i, in bits [32i+31:32i], IEEE-754 single precision.
- `req_b`, input, 32*`NREQ`: operand B, same packing as `req_a`.
- `req_rm`, input, 2*`NREQ`: rounding mode for requester i, in bits [2i+1:2i].
  - 00 = toward zero.
  - 01 = nearest even.
  - 10 = toward +inf.
  - 11 = toward -inf.
- `out_valid`, output, 1: a result is held in the output register.
- `out_ready`, input, 1: the consumer accepts the result.
- `out_result`, output, 32: sum.
- `out_overflow`, output, 1: the adder's overflow indication.
- `out_error`, output, 1: the adder's error indication.
- `out_id`, output, `IDW`: index of the requester that owns the result.
- `busy`, output, 1: high in every state except IDLE.

## Operation

State machine with three states: IDLE, EXEC, DONE.

IDLE:
- If any `req_valid` bit is set, choose the first set bit searching upward, with wrap, from `last_grant`+1.
- Assert the corresponding `req_ready` bit combinationally.
- Latch `req_a`, `req_b`, `req_rm` and the index into the operand registers.
- Set `last_grant` to the index and go to EXEC.
- With no `req_valid`, stay in IDLE. `req_ready` is all-zero.

EXEC:
- The operand registers drive `Adder`.
- At the clock edge, capture into the output registers:
  - `resultAdd` into `out_result`.
  - `overflowAdd` into `out_overflow`.
  - `errorAdd` into `out_error`.
  - The latched index into `out_id`.
- Go to DONE.
- If `overflowAdd` is 1, capture `out_result` = {latched A[31], 8'hFF, 23'h0} instead of `resultAdd`, which is stale on overflow.

DONE:
- `out_valid`=1. The output registers are stable.
- When `out_ready`=1, go to IDLE.
- No request is accepted in the same cycle as the handoff.

Rules that hold in every state:
- `req_ready` is zero in EXEC and DONE.
- `req_ready` never has more than one bit set.
- The operand registers and output registers load only on the transitions above.
- A requester that drops `req_valid` before it is granted loses nothing. No state is kept per requester.
- Any `req_valid` bit may be set in any state. Only IDLE samples them.

Reset, when `rst`=1 at an edge:
- State returns to IDLE, including from mid-EXEC or mid-DONE. A pending result is discarded and `out_valid` falls.
- `last_grant` = `NREQ`-1, so requester 0 has first priority after reset.
- Output reset values: `out_valid`=0, `out_result`=0, `out_overflow`=0, `out_error`=0, `out_id`=0, `busy`=0, `req_ready`=0.
- While `rst` is high, `req_ready` is forced to 0 regardless of `req_valid`.

## Timing

- Accept at edge N, meaning `req_valid` and `req_ready` are both high in the cycle before edge N.
- State is EXEC during cycle N to N+1. `out_valid`=1 from edge N+1.
- Minimum latency from accept to `out_valid` is 1 cycle.
- The minimum issue interval is 3 cycles when `out_ready` is held high: IDLE, EXEC, DONE, back to IDLE.
- Backpressure: DONE persists any number of cycles. `out_*` must not change while `out_valid`=1 and `out_ready`=0.
- `busy` is a function of the registered state only.
- `req_ready` is combinational from the state, `req_valid` and `last_grant`. It has no dependency on `out_ready`.

## Test plan

- Reset, then requester 0 only, with A=0x3F800000, B=0x40000000, rm=00, and `out_ready`=1:
  - `req_ready`=0001 in the first cycle.
  - `out_valid` rises exactly 2 edges after the request is presented.
  - `out_result`=0x40400000, `out_id`=0, `out_overflow`=0.
- All four `req_valid` held high, each with A=B=0x3F800000:
  - Grants occur in order 0,1,2,3,0.
  - Each result is 0x40000000 with the matching `out_id`.
  - Grants are spaced 3 cycles apart.
- Requesters 1 and 3 valid, with `last_grant`=1:
  - The next grant goes to 3, then to 1. Requesters 0 and 2 are never granted.
- A=B=0x7F000000 on requester 2:
  - `out_overflow`=1, `out_error`=1, `out_result`=0x7F800000, `out_id`=2.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE while `req_valid`=1111:
  - `out_*` remain stable and `req_ready` stays 0000.
  - Raise `out_ready` for one cycle: the next cycle is IDLE and a grant is issued.
- Assert `rst` for one cycle while in EXEC:
  - The next cycle is IDLE with `out_valid`=0 and `busy`=0.
  - The subsequent grant goes to requester 0 when 0 and 1 are both valid.
